// File: rtl/fios_mm_arbiter.sv
// Round-robin arbiter sharing one FIOS Montgomery multiplier among NREQ requesters.
// Optional watchdog abort path enabled by defining FIOS_MM_ARBITER_WDOG_EN.
module fios_mm_arbiter #(
   parameter int NREQ        = 4,
   parameter int s           = 8,
   parameter int PE_NB       = 8,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic                      clock_i,
   input  logic                      reset_n_i,
   input  logic [NREQ-1:0]           req_i,
   output logic [NREQ-1:0]           gnt_o,
   input  logic [NREQ*17-1:0]        req_p_prime_0_i,
   input  logic [NREQ*PE_NB*17-1:0]  req_a_i,
   input  logic [NREQ*17-1:0]        req_b_i,
   input  logic [NREQ*17-1:0]        req_p_i,
   output logic [NREQ-1:0]           a_shift_o,
   output logic [NREQ-1:0]           b_fetch_o,
   output logic [NREQ-1:0]           p_fetch_o,
   output logic [NREQ-1:0]           res_valid_o,
   output logic [16:0]               res_o,
   output logic [NREQ-1:0]           job_done_o,
   output logic [NREQ-1:0]           abort_o,
   output logic                      err_o,
   output logic                      busy_o,
   output logic                      mm_start_o,
   output logic                      mm_flush_o,
   output logic [16:0]               mm_p_prime_0_o,
   output logic [16:0]               mm_b_o,
   output logic [16:0]               mm_p_o,
   output logic [PE_NB*17-1:0]       mm_a_o,
   input  logic                      mm_a_shift_i,
   input  logic                      mm_b_fetch_i,
   input  logic                      mm_p_fetch_i,
   input  logic                      mm_res_push_i,
   input  logic                      mm_done_i,
   input  logic [16:0]               mm_res_i
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(s + 1);
   localparam int AW = PE_NB * 17;

   if (NREQ < 2 || NREQ > 8 || s < 1 || WDOG_CYCLES < 2) begin : g_bad_param
      $error("fios_mm_arbiter: parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, GRANT, START, RUN, DONE, FLUSH} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   owner, rr_ptr, pick, sel;
   logic            pick_vld;
   logic [CW-1:0]   res_cnt;
   logic [NREQ-1:0] owner_oh;
   logic            run, strobe_any, flush_first, job_end;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
      int t;
      t = int'(base) + k;
      if (t >= NREQ) t -= NREQ;
      return IW'(t);
   endfunction

   // Scan downward so the first set bit at or after rr_ptr wins.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_i[wrap_add(rr_ptr, k)]) begin
            pick     = wrap_add(rr_ptr, k);
            pick_vld = 1'b1;
         end
      end
   end

   assign owner_oh   = NREQ'(1) << owner;
   assign run        = (state == RUN);
   assign strobe_any = mm_a_shift_i | mm_b_fetch_i | mm_p_fetch_i | mm_res_push_i | mm_done_i;
   assign job_end    = (state == DONE) | flush_first;

   // Operand mux parks on requester 0 while idle.
   assign sel            = (state == IDLE) ? '0 : owner;
   assign mm_a_o         = req_a_i[sel*AW +: AW];
   assign mm_b_o         = req_b_i[sel*17 +: 17];
   assign mm_p_o         = req_p_i[sel*17 +: 17];
   assign mm_p_prime_0_o = req_p_prime_0_i[sel*17 +: 17];
   assign res_o          = mm_res_i;

   assign a_shift_o   = {NREQ{run & mm_a_shift_i}}  & owner_oh;
   assign b_fetch_o   = {NREQ{run & mm_b_fetch_i}}  & owner_oh;
   assign p_fetch_o   = {NREQ{run & mm_p_fetch_i}}  & owner_oh;
   assign res_valid_o = {NREQ{run & mm_res_push_i}} & owner_oh;

`ifdef FIOS_MM_ARBITER_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_cnt;
   logic          flush_ph;

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         wdog_cnt <= '0;
         flush_ph <= 1'b0;
      end else begin
         if (state == START)  wdog_cnt <= '0;
         else if (run)        wdog_cnt <= wdog_cnt + 1'b1;
         flush_ph <= (state == FLUSH) && !flush_ph;
      end
   end

   assign flush_first = (state == FLUSH) && !flush_ph;
   assign abort_o     = {NREQ{flush_first}} & owner_oh;
   assign mm_flush_o  = flush_first;
`else
   assign flush_first = 1'b0;
   assign abort_o     = '0;
   assign mm_flush_o  = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      gnt_o      = '0;
      job_done_o = '0;
      mm_start_o = 1'b0;
      busy_o     = (state != IDLE);
      case (state)
         IDLE:  if (pick_vld) state_nxt = GRANT;
         GRANT: begin
            gnt_o     = owner_oh;
            state_nxt = START;
         end
         START: begin
            gnt_o      = owner_oh;
            mm_start_o = 1'b1;
            state_nxt  = RUN;
         end
         RUN: begin
            gnt_o = owner_oh;
            if (mm_done_i) state_nxt = DONE;
`ifdef FIOS_MM_ARBITER_WDOG_EN
            else if (wdog_cnt == WW'(WDOG_CYCLES - 1)) state_nxt = FLUSH;
`endif
         end
         DONE: begin
            gnt_o      = owner_oh;
            job_done_o = owner_oh;
            state_nxt  = IDLE;
         end
         FLUSH: begin
            job_done_o = {NREQ{flush_first}} & owner_oh;
`ifdef FIOS_MM_ARBITER_WDOG_EN
            if (flush_ph) state_nxt = IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state   <= IDLE;
         owner   <= '0;
         rr_ptr  <= '0;
         res_cnt <= '0;
         err_o   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_vld) owner <= pick;
         if (state == START)
            res_cnt <= '0;
         else if (run && mm_res_push_i && res_cnt != CW'(s))
            res_cnt <= res_cnt + 1'b1;
         if (job_end) rr_ptr <= wrap_add(owner, 1);
         // Strobes outside RUN, short result, or watchdog abort are all protocol errors.
         if ((!run && strobe_any) || (state == DONE && res_cnt != CW'(s)) || flush_first)
            err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fios_mm_arbiter.sv
// Directed self-checking bench for fios_mm_arbiter (NREQ=4, s=8, PE_NB=8, WDOG_CYCLES=16).
module tb_fios_mm_arbiter;
   localparam int NREQ = 4, S = 8, PE_NB = 8, WD = 16;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]          req_i = '0;
   logic [NREQ-1:0]          gnt_o, a_shift_o, b_fetch_o, p_fetch_o, res_valid_o, job_done_o, abort_o;
   logic [NREQ*17-1:0]       req_pp0 = '0, req_b = '0, req_p = '0;
   logic [NREQ*PE_NB*17-1:0] req_a = '0;
   logic [16:0]              res_o, mm_pp0, mm_b, mm_p, mm_res = '0;
   logic [PE_NB*17-1:0]      mm_a;
   logic                     err_o, busy_o, mm_start_o, mm_flush_o;
   logic                     a_sh = 0, b_fe = 0, p_fe = 0, push = 0, done = 0;

   int checks = 0, errors = 0;

   fios_mm_arbiter #(.NREQ(NREQ), .s(S), .PE_NB(PE_NB), .WDOG_CYCLES(WD)) dut (
      .clock_i(clk), .reset_n_i(rst_n), .req_i(req_i), .gnt_o(gnt_o),
      .req_p_prime_0_i(req_pp0), .req_a_i(req_a), .req_b_i(req_b), .req_p_i(req_p),
      .a_shift_o(a_shift_o), .b_fetch_o(b_fetch_o), .p_fetch_o(p_fetch_o),
      .res_valid_o(res_valid_o), .res_o(res_o), .job_done_o(job_done_o), .abort_o(abort_o),
      .err_o(err_o), .busy_o(busy_o), .mm_start_o(mm_start_o), .mm_flush_o(mm_flush_o),
      .mm_p_prime_0_o(mm_pp0), .mm_b_o(mm_b), .mm_p_o(mm_p), .mm_a_o(mm_a),
      .mm_a_shift_i(a_sh), .mm_b_fetch_i(b_fe), .mm_p_fetch_i(p_fe),
      .mm_res_push_i(push), .mm_done_i(done), .mm_res_i(mm_res));

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_i = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic start_job(input logic [3:0] req, input int o);
      req_i = req;
      tick();
      checks++;
      if (gnt_o !== 4'(1 << o) || busy_o !== 1'b1) begin
         errors++; $display("FAIL grant: gnt %b busy %b, want %b busy 1", gnt_o, busy_o, 4'(1 << o));
      end
      tick();
      checks++;
      if (mm_start_o !== 1'b1 || gnt_o !== 4'(1 << o)) begin
         errors++; $display("FAIL start: start %b gnt %b, want 1 %b", mm_start_o, gnt_o, 4'(1 << o));
      end
      tick();
      checks++;
      if (mm_start_o !== 1'b0) begin
         errors++; $display("FAIL start_len: start %b in RUN, want 0", mm_start_o);
      end
   endtask

   task automatic finish_job(input int o, input int npush, input bit last_with_done);
      int nsep;
      nsep = last_with_done ? npush - 1 : npush;
      for (int w = 0; w < nsep; w++) begin
         push = 1'b1; mm_res = 17'(w * 3 + 5);
         #1;
         checks++;
         if (res_valid_o !== 4'(1 << o) || res_o !== 17'(w * 3 + 5)) begin
            errors++; $display("FAIL res_push: valid %b res %h, want %b %h", res_valid_o, res_o, 4'(1 << o), 17'(w * 3 + 5));
         end
         tick();
         push = 1'b0;
      end
      done = 1'b1; push = last_with_done;
      tick();
      done = 1'b0; push = 1'b0;
      checks++;
      if (job_done_o !== 4'(1 << o) || gnt_o !== 4'(1 << o)) begin
         errors++; $display("FAIL job_done: done %b gnt %b, want %b", job_done_o, gnt_o, 4'(1 << o));
      end
      tick();
      checks++;
      if (job_done_o !== 4'b0 || busy_o !== 1'b0 || gnt_o !== 4'b0) begin
         errors++; $display("FAIL after_done: done %b busy %b gnt %b, want 0 0 0", job_done_o, busy_o, gnt_o);
      end
   endtask

   task automatic test_reset();
      req_i = 4'b1111; push = 1'b1;
      tick(); tick();
      checks++;
      if (gnt_o !== 4'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || mm_start_o !== 1'b0 ||
          mm_flush_o !== 1'b0 || job_done_o !== 4'b0 || abort_o !== 4'b0 || res_valid_o !== 4'b0) begin
         errors++; $display("FAIL reset_state: gnt %b busy %b err %b start %b", gnt_o, busy_o, err_o, mm_start_o);
      end
      checks++;
      if (mm_b !== req_b[16:0] || mm_a !== req_a[PE_NB*17-1:0]) begin
         errors++; $display("FAIL idle_mux: b %h want %h", mm_b, req_b[16:0]);
      end
      push = 1'b0; req_i = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_job();
      start_job(4'b0100, 2);
      req_i = '0;
      finish_job(2, 8, 1'b0);
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL single_err: err %b want 0", err_o);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         start_job(4'b1111, k % 4);
         finish_job(k % 4, 8, 1'b0);
      end
      req_i = '0;
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL rr_err: err %b want 0", err_o);
      end
   endtask

   task automatic test_routing();
      start_job(4'b0010, 1);
      req_i = '0;
      checks++;
      if (mm_b !== req_b[33:17] || mm_p !== req_p[33:17] || mm_pp0 !== req_pp0[33:17] ||
          mm_a !== req_a[2*PE_NB*17-1:PE_NB*17]) begin
         errors++; $display("FAIL operand_mux: b %h p %h pp0 %h, want %h %h %h", mm_b, mm_p, mm_pp0,
                            req_b[33:17], req_p[33:17], req_pp0[33:17]);
      end
      b_fe = 1'b1; #1;
      checks++;
      if (b_fetch_o !== 4'b0010 || p_fetch_o !== 4'b0 || a_shift_o !== 4'b0) begin
         errors++; $display("FAIL route_b: b %b p %b a %b, want 0010 0000 0000", b_fetch_o, p_fetch_o, a_shift_o);
      end
      tick(); b_fe = 1'b0; p_fe = 1'b1; #1;
      checks++;
      if (p_fetch_o !== 4'b0010 || b_fetch_o !== 4'b0 || a_shift_o !== 4'b0) begin
         errors++; $display("FAIL route_p: p %b b %b a %b, want 0010 0000 0000", p_fetch_o, b_fetch_o, a_shift_o);
      end
      tick(); p_fe = 1'b0; a_sh = 1'b1; #1;
      checks++;
      if (a_shift_o !== 4'b0010 || b_fetch_o !== 4'b0 || p_fetch_o !== 4'b0) begin
         errors++; $display("FAIL route_a: a %b b %b p %b, want 0010 0000 0000", a_shift_o, b_fetch_o, p_fetch_o);
      end
      tick(); a_sh = 1'b0;
      // Final push lands in the same cycle as done and must still count.
      finish_job(1, 8, 1'b1);
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL push_with_done: err %b want 0", err_o);
      end
   endtask

   task automatic test_short_result();
      start_job(4'b1000, 3);
      req_i = '0;
      finish_job(3, 7, 1'b0);
      checks++;
      if (err_o !== 1'b1) begin
         errors++; $display("FAIL short_err: err %b want 1", err_o);
      end
      start_job(4'b0001, 0);
      req_i = '0;
      finish_job(0, 8, 1'b0);
      checks++;
      if (err_o !== 1'b1) begin
         errors++; $display("FAIL err_sticky: err %b want 1", err_o);
      end
      do_reset();
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL err_clear: err %b want 0", err_o);
      end
      push = 1'b1; #1;
      checks++;
      if (res_valid_o !== 4'b0) begin
         errors++; $display("FAIL stray_route: valid %b want 0000", res_valid_o);
      end
      tick(); push = 1'b0;
      checks++;
      if (err_o !== 1'b1) begin
         errors++; $display("FAIL stray_err: err %b want 1", err_o);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_job();
      start_job(4'b0100, 2);
      req_i = '0;
      for (int w = 0; w < 3; w++) begin
         push = 1'b1; tick(); push = 1'b0;
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (busy_o !== 1'b0 || gnt_o !== 4'b0 || job_done_o !== 4'b0 || mm_start_o !== 1'b0) begin
         errors++; $display("FAIL mid_reset: busy %b gnt %b done %b, want 0", busy_o, gnt_o, job_done_o);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (job_done_o !== 4'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL mid_reset_quiet: done %b busy %b, want 0", job_done_o, busy_o);
      end
      start_job(4'b1111, 0);
      req_i = '0;
      finish_job(0, 8, 1'b0);
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL mid_reset_err: err %b want 0", err_o);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      start_job(4'b0011, 0);
`ifdef FIOS_MM_ARBITER_WDOG_EN
      repeat (WD - 1) tick();
      checks++;
      if (abort_o !== 4'b0 || mm_flush_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++; $display("FAIL wdog_early: abort %b flush %b busy %b", abort_o, mm_flush_o, busy_o);
      end
      tick();
      checks++;
      if (abort_o !== 4'b0001 || job_done_o !== 4'b0001 || mm_flush_o !== 1'b1) begin
         errors++; $display("FAIL wdog_abort: abort %b done %b flush %b, want 0001 0001 1", abort_o, job_done_o, mm_flush_o);
      end
      tick();
      checks++;
      if (abort_o !== 4'b0 || job_done_o !== 4'b0 || mm_flush_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++; $display("FAIL wdog_flush2: abort %b done %b flush %b busy %b", abort_o, job_done_o, mm_flush_o, busy_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b0 || err_o !== 1'b1) begin
         errors++; $display("FAIL wdog_idle: busy %b err %b, want 0 1", busy_o, err_o);
      end
      tick();
      checks++;
      if (gnt_o !== 4'b0010) begin
         errors++; $display("FAIL wdog_next: gnt %b want 0010", gnt_o);
      end
`else
      repeat (3 * WD) tick();
      checks++;
      if (busy_o !== 1'b1 || gnt_o !== 4'b0001 || abort_o !== 4'b0 || mm_flush_o !== 1'b0 || job_done_o !== 4'b0) begin
         errors++; $display("FAIL no_wdog: busy %b gnt %b abort %b flush %b", busy_o, gnt_o, abort_o, mm_flush_o);
      end
`endif
      do_reset();
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         req_pp0[i*17 +: 17] = 17'(16'h1000 + i);
         req_b[i*17 +: 17]   = 17'(16'h0200 + i);
         req_p[i*17 +: 17]   = 17'(16'h0300 + i);
         for (int j = 0; j < PE_NB; j++) req_a[(i*PE_NB + j)*17 +: 17] = 17'(i * 16 + j + 1);
      end
      test_reset();
      test_single_job();
      test_round_robin();
      test_routing();
      test_short_result();
      test_reset_mid_job();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
